l2_vec_packer: RTL

Upstream feeder for the L2-norm AXIS stage. It accepts one signed element per cycle on a valid/ready stream and packs LANES elements into each 64-bit AXIS beat. Each vector has a runtime-configured length; the block frames it with tuser on the first beat, tlast on the final beat, and tkeep byte masking on a partial final beat. A 2-entry output buffer decouples the element side from downstream backpressure.

---
 rtl/l2_pkg.sv | 33 +++
 rtl/l2_beat_fifo2.sv | 70 +++++++
 rtl/l2_vec_packer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/l2_pkg.sv
// Shared types and constants for the L2-norm vector packer.
package l2_pkg;

    localparam int ELEM_W = 16;
    localparam int LANES  = 4;
    localparam int DATA_W = 64;
    localparam int KEEP_W = DATA_W / 8;

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } pack_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [KEEP_W-1:0] keep;
        logic              user;
        logic              last;
    } beat_t;

    // Contiguous byte-enable prefix covering the first nlanes lanes.
    function automatic logic [KEEP_W-1:0] keep_mask(input int unsigned nlanes);
        logic [KEEP_W-1:0] m;
        m = '0;
        for (int unsigned b = 0; b < KEEP_W; b++) begin
            if (b < nlanes * (ELEM_W / 8)) begin
                m[b] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/l2_beat_fifo2.sv
// Two-entry beat FIFO; head entry is held in its own register so outputs come straight from flops.
module l2_beat_fifo2
    import l2_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        push_i,
    input  beat_t       din_i,
    input  logic        pop_i,
    output beat_t       head_o,
    output logic [1:0]  count_o,
    output logic        full_o,
    output logic        empty_o
);

    beat_t      head_q, head_d;
    beat_t      tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       do_pop, do_push;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        do_pop  = pop_i && (count_q != 2'd0);
        do_push = push_i && ((count_q != 2'd2) || do_pop);
        unique case ({do_push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = din_i;
                end else begin
                    tail_d = din_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Occupancy unchanged: new beat lands behind whatever stays.
                if (count_q == 2'd1) begin
                    head_d = din_i;
                end else begin
                    head_d = tail_q;
                    tail_d = din_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head_o  = head_q;
    assign count_o = count_q;
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);

endmodule

// File: rtl/l2_vec_packer.sv
// Packs a stream of signed elements into framed 64-bit AXIS beats (tuser/tlast/tkeep) per vector.
module l2_vec_packer
    import l2_pkg::*;
#(
    parameter int ELEM_W = l2_pkg::ELEM_W,
    parameter int LANES  = l2_pkg::LANES,
    parameter int LEN_W  = 16
)(
    input  logic              clock,
    input  logic              reset,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [ELEM_W-1:0] s_elem_tdata,
    input  logic              s_elem_tvalid,
    output logic              s_elem_tready,
    output logic [63:0]       m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tuser,
    output logic [7:0]        m_tkeep,
    output logic              m_tlast,
    output logic              busy,
    output logic              err_len
);

    localparam int LANE_IW = (LANES > 1) ? $clog2(LANES) : 1;

    if (ELEM_W * LANES != DATA_W) begin : g_bad_geometry
        $error("ELEM_W*LANES must equal 64");
    end

    pack_state_e        state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [LANE_IW-1:0] lane_q, lane_d;
    logic [DATA_W-1:0]  asm_q, asm_d;
    logic               err_q, err_d;
    logic               en_q;

    logic               accept, vec_end, beat_done;
    logic [LEN_W-1:0]   cur_len;
    logic [DATA_W-1:0]  beat_data;
    beat_t              push_beat, head;
    logic [1:0]         fcount;
    logic               ffull, fempty;

    assign accept = s_elem_tvalid && s_elem_tready;

    always_comb begin
        // In IDLE the incoming element starts a vector, so frame it with the live cfg_len.
        cur_len = len_q;
        if (state_q == ST_IDLE) begin
            cur_len = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
        end
        vec_end   = ((cnt_q + LEN_W'(1)) == cur_len);
        beat_done = accept && ((lane_q == LANE_IW'(LANES - 1)) || vec_end);

        beat_data = asm_q;
        beat_data[lane_q * ELEM_W +: ELEM_W] = s_elem_tdata;

        push_beat.data = beat_data;
        push_beat.keep = keep_mask(32'(lane_q) + 32'd1);
        push_beat.user = (cnt_q < LEN_W'(LANES));
        push_beat.last = vec_end;

        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        lane_d  = lane_q;
        asm_d   = asm_q;
        err_d   = 1'b0;

        if (accept) begin
            len_d = cur_len;
            err_d = (state_q == ST_IDLE) && (cfg_len == '0);
            if (vec_end) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                lane_d  = '0;
                asm_d   = '0;
            end else begin
                state_d = ST_FILL;
                cnt_d   = cnt_q + LEN_W'(1);
                lane_d  = beat_done ? '0 : lane_q + LANE_IW'(1);
                asm_d   = beat_done ? '0 : beat_data;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            lane_q  <= '0;
            asm_q   <= '0;
            err_q   <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            lane_q  <= lane_d;
            asm_q   <= asm_d;
            err_q   <= err_d;
            en_q    <= 1'b1;
        end
    end

    l2_beat_fifo2 u_fifo (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (beat_done && !ffull),
        .din_i   (push_beat),
        .pop_i   (m_tvalid && m_tready),
        .head_o  (head),
        .count_o (fcount),
        .full_o  (ffull),
        .empty_o (fempty)
    );

    assign s_elem_tready = en_q && (fcount <= 2'd1);
    assign m_tvalid      = !fempty;
    assign m_tdata       = head.data;
    assign m_tkeep       = head.keep;
    assign m_tuser       = head.user;
    assign m_tlast       = head.last;
    assign busy          = (state_q == ST_FILL);
    assign err_len       = err_q;

endmodule
